uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_counter.sv | 28 ++
 rtl/uart_tx_sequencer.sv | 105 ++++++++++
 tb/tb_uart_tx_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer bit-type select encodings, the
// transmit sequencer state type and a parity helper.
package uart_pkg;

  localparam logic [2:0] SEL_IDLE   = 3'b000;
  localparam logic [2:0] SEL_START  = 3'b001;
  localparam logic [2:0] SEL_DATA   = 3'b010;
  localparam logic [2:0] SEL_PARITY = 3'b011;
  localparam logic [2:0] SEL_STOP   = 3'b100;

  localparam int         DATA_BITS = 8;
  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Odd parity is the complement of the XOR-reduce so that the total
  // count of ones including the parity bit is odd.
  function automatic logic calc_parity(input logic [7:0] d, input logic odd);
    return odd ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: free-runs while enabled and ticks on the last cycle
// of each CLKS_PER_BIT window; clear restarts the window.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  assign tick = enable && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: walks START, DATA[0..7], optional PARITY, STOP
// and tells the serializer which bit to load on each bit boundary.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] data_q,
  output logic [2:0] out_sel,
  output logic [2:0] counter_i,
  output logic       end_bit_time,
  output logic       parity
);

  tx_state_t state_reg;
  logic      accept;
  logic      tick;

  // The tx_done cycle already shows tx_busy low, so it is excluded
  // explicitly to keep back-to-back frames one cycle apart.
  assign accept = tx_start && !tx_busy && !tx_done;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (accept || tick),
    .enable(tx_busy),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      out_sel      <= SEL_IDLE;
      counter_i    <= 3'd0;
      end_bit_time <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      data_q       <= 8'd0;
      parity       <= 1'b0;
    end else begin
      end_bit_time <= 1'b0;
      tx_done      <= 1'b0;
      if (accept) begin
        state_reg    <= ST_START;
        out_sel      <= SEL_START;
        counter_i    <= 3'd0;
        end_bit_time <= 1'b1;
        tx_busy      <= 1'b1;
        data_q       <= tx_data;
        parity       <= calc_parity(tx_data, PARITY_ODD);
      end else if (tick) begin
        end_bit_time <= 1'b1;
        case (state_reg)
          ST_START: begin
            state_reg <= ST_DATA;
            out_sel   <= SEL_DATA;
            counter_i <= 3'd0;
          end
          ST_DATA: begin
            if (counter_i == LAST_IDX) begin
              counter_i <= 3'd0;
              if (PARITY_EN) begin
                state_reg <= ST_PARITY;
                out_sel   <= SEL_PARITY;
              end else begin
                state_reg <= ST_STOP;
                out_sel   <= SEL_STOP;
              end
            end else begin
              counter_i <= counter_i + 3'd1;
            end
          end
          ST_PARITY: begin
            state_reg <= ST_STOP;
            out_sel   <= SEL_STOP;
          end
          ST_STOP: begin
            state_reg <= ST_IDLE;
            out_sel   <= SEL_IDLE;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b1;
          end
          default: begin
            state_reg <= ST_IDLE;
            out_sel   <= SEL_IDLE;
            counter_i <= 3'd0;
            tx_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: three parameterisations share stimulus; the
// selected one is checked against a scoreboard of expected bit boundaries.
module tb_uart_tx_sequencer;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'd0;

  logic       busy0, done0, ebt0, par0, busy1, done1, ebt1, par1, busy2, done2, ebt2, par2;
  logic [7:0] dq0, dq1, dq2;
  logic [2:0] sel0, sel1, sel2, idx0, idx1, idx2;

  uart_tx_sequencer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(busy0),
    .tx_done(done0), .data_q(dq0), .out_sel(sel0), .counter_i(idx0),
    .end_bit_time(ebt0), .parity(par0));

  uart_tx_sequencer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(busy1),
    .tx_done(done1), .data_q(dq1), .out_sel(sel1), .counter_i(idx1),
    .end_bit_time(ebt1), .parity(par1));

  uart_tx_sequencer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(busy2),
    .tx_done(done2), .data_q(dq2), .out_sel(sel2), .counter_i(idx2),
    .end_bit_time(ebt2), .parity(par2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int mon = 0;
  logic seen_par_np = 1'b0;

  typedef struct {
    logic [2:0] sel;
    logic [2:0] idx;
    logic       bit_v;
    int         cyc;
    logic       done;
  } exp_t;
  exp_t sb[$];

  logic       m_ebt, m_done, m_par;
  logic [2:0] m_sel, m_idx;
  logic [7:0] m_dq;
  assign m_ebt  = (mon == 1) ? ebt1  : (mon == 2) ? ebt2  : ebt0;
  assign m_done = (mon == 1) ? done1 : (mon == 2) ? done2 : done0;
  assign m_par  = (mon == 1) ? par1  : (mon == 2) ? par2  : par0;
  assign m_sel  = (mon == 1) ? sel1  : (mon == 2) ? sel2  : sel0;
  assign m_idx  = (mon == 1) ? idx1  : (mon == 2) ? idx2  : idx0;
  assign m_dq   = (mon == 1) ? dq1   : (mon == 2) ? dq2   : dq0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Serializer model: the line level loaded when end_bit_time strobes.
  function automatic logic line_bit(input logic [2:0] s, input logic [7:0] d,
                                    input logic [2:0] i, input logic p);
    case (s)
      SEL_START:  return 1'b0;
      SEL_DATA:   return d[i];
      SEL_PARITY: return p;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic push_one(input logic [2:0] s, input logic [2:0] i, input logic b,
                          input int c, input logic dn);
    exp_t e;
    e.sel = s; e.idx = i; e.bit_v = b; e.cyc = c; e.done = dn;
    sb.push_back(e);
  endtask

  // Expected bit boundaries for a frame accepted in cycle t.
  task automatic push_frame(input int t, input logic [7:0] d, input logic pen,
                            input logic odd, input int limit);
    int n_ent;
    n_ent = pen ? 12 : 11;
    for (int k = 0; k < n_ent && k < limit; k++) begin
      int c;
      c = t + 1 + k * CPB;
      if (k == 0)                push_one(SEL_START, 3'd0, 1'b0, c, 1'b0);
      else if (k <= 8)           push_one(SEL_DATA, 3'(k - 1), d[k-1], c, 1'b0);
      else if (pen && k == 9)    push_one(SEL_PARITY, 3'd0, odd ? ~(^d) : (^d), c, 1'b0);
      else if (k == n_ent - 1)   push_one(SEL_IDLE, 3'd0, 1'b1, c, 1'b1);
      else                       push_one(SEL_STOP, 3'd0, 1'b1, c, 1'b0);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sel2 == SEL_PARITY) seen_par_np = 1'b1;
    if (m_ebt) begin
      check("sb_nonempty_at_ebt", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_sel", 32'(m_sel), 32'(mon_e.sel));
        check("counter_i", 32'(m_idx), 32'(mon_e.idx));
        check("ebt_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("tx_done", 32'(m_done), 32'(mon_e.done));
        check("line_bit", 32'(line_bit(m_sel, m_dq, m_idx, m_par)), 32'(mon_e.bit_v));
        if (mon_e.done)
          $display("frame inst=%0d data_q=%02h parity=%0b done at cycle %0d", mon, m_dq, m_par, cyc);
      end
    end else if (m_done) begin
      check("tx_done_without_ebt", 32'(m_ebt), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending_after_wait"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t;
  initial begin
    // Reset with tx_start asserted: must stay idle.
    rst = 1'b1; tx_start = 1'b1; tx_data = 8'hFF;
    step(3);
    @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_ebt", 32'(ebt0), 32'd0);
    check("rst_sel", 32'(sel0), 32'd0);
    check("rst_idx", 32'(idx0), 32'd0);
    check("rst_dq", 32'(dq0), 32'd0);
    check("rst_par", 32'(par0), 32'd0);
    check("rst_busy_odd", 32'(busy1), 32'd0);
    check("rst_busy_np", 32'(busy2), 32'd0);
    step(1);
    rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00;

    // A: 0xA5 even parity, mid-frame start pulse and data change ignored.
    mon = 0;
    step(2);
    t = cyc; tx_data = 8'hA5; tx_start = 1'b1;
    push_frame(t, 8'hA5, 1'b1, 1'b0, 99);
    step(1);
    tx_start = 1'b0;
    @(negedge clk);
    check("a_busy", 32'(busy0), 32'd1);
    check("a_dq", 32'(dq0), 32'hA5);
    check("a_par", 32'(par0), 32'd0);
    step(9);
    tx_data = 8'h3C; tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    @(negedge clk);
    check("a_dq_hold", 32'(dq0), 32'hA5);
    check("a_par_hold", 32'(par0), 32'd0);
    wait_sb("a", 80);
    @(negedge clk);
    check("a_idle_busy", 32'(busy0), 32'd0);
    check("a_idle_ebt", 32'(ebt0), 32'd0);
    step(6);

    // B: odd parity on 0x01 and 0x03.
    mon = 1;
    t = cyc; tx_data = 8'h01; tx_start = 1'b1;
    push_frame(t, 8'h01, 1'b1, 1'b1, 99);
    step(1);
    tx_start = 1'b0;
    @(negedge clk);
    check("b_par_01", 32'(par1), 32'd0);
    check("b_dq_01", 32'(dq1), 32'h01);
    wait_sb("b1", 80);
    step(6);
    t = cyc; tx_data = 8'h03; tx_start = 1'b1;
    push_frame(t, 8'h03, 1'b1, 1'b1, 99);
    step(1);
    tx_start = 1'b0;
    @(negedge clk);
    check("b_par_03", 32'(par1), 32'd1);
    wait_sb("b2", 80);
    step(6);

    // C: no parity, 0xFF, frame ends at T+41.
    mon = 2;
    t = cyc; tx_data = 8'hFF; tx_start = 1'b1;
    push_frame(t, 8'hFF, 1'b0, 1'b0, 99);
    step(1);
    tx_start = 1'b0;
    wait_sb("c", 80);
    step(6);

    // D: tx_start held high, second frame accepted the cycle after tx_done.
    mon = 0;
    t = cyc; tx_data = 8'h5A; tx_start = 1'b1;
    push_frame(t, 8'h5A, 1'b1, 1'b0, 99);
    push_frame(t + 46, 8'hC3, 1'b1, 1'b0, 99);
    step(20);
    tx_data = 8'hC3;
    step(27);
    tx_start = 1'b0;
    @(negedge clk);
    check("d_second_busy", 32'(busy0), 32'd1);
    check("d_second_dq", 32'(dq0), 32'hC3);
    wait_sb("d", 120);
    step(6);

    // E: reset at T+20 aborts the frame without tx_done.
    t = cyc; tx_data = 8'h96; tx_start = 1'b1;
    push_frame(t, 8'h96, 1'b1, 1'b0, 5);
    step(1);
    tx_start = 1'b0;
    step(19);
    rst = 1'b1;
    step(1);
    tx_start = 1'b1;
    @(negedge clk);
    check("e_partial_consumed", 32'(sb.size()), 32'd0);
    check("e_rst_busy", 32'(busy0), 32'd0);
    check("e_rst_done", 32'(done0), 32'd0);
    check("e_rst_ebt", 32'(ebt0), 32'd0);
    check("e_rst_sel", 32'(sel0), 32'd0);
    check("e_rst_idx", 32'(idx0), 32'd0);
    check("e_rst_dq", 32'(dq0), 32'd0);
    check("e_rst_par", 32'(par0), 32'd0);
    step(1);
    rst = 1'b0; tx_start = 1'b0;
    @(negedge clk);
    check("e_start_during_rst_ignored", 32'(busy0), 32'd0);
    step(50);
    t = cyc; tx_data = 8'h3C; tx_start = 1'b1;
    push_frame(t, 8'h3C, 1'b1, 1'b0, 99);
    step(1);
    tx_start = 1'b0;
    wait_sb("e", 80);
    step(6);

    check("np_never_parity_sel", 32'(seen_par_np), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
